// File: rtl/jmp_seq_fsm_pkg.sv
// Shared defaults, the idle-state constant and parameter legality check for jmp_seq_fsm.
package fsm_pkg;

  localparam int NSTATES_DEF   = 10;
  localparam int JMP_STATE_DEF = 3;
  localparam int CNT_W_DEF     = 8;
  localparam int S_IDLE        = 0;

  // Kind of state move chosen by the sequencer for the coming edge.
  typedef enum logic [1:0] {
    MV_STAY,
    MV_NEXT,
    MV_JUMP,
    MV_IDLE
  } move_e;

  function automatic bit params_ok(input int nstates, input int jmp_state, input int cnt_w);
    return (nstates >= 3) && (jmp_state >= 1) && (jmp_state <= nstates - 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/jmp_seq_fsm_if.sv
// Strobe inputs and status outputs of jmp_seq_fsm; the sequencer takes the slave side.
interface jmp_seq_fsm_if #(
  parameter int SW    = 4,
  parameter int CNT_W = 8
);
  logic             go;
  logic             jmp;
  logic             hold;
  logic             abort;
  logic             y1;
  logic             busy;
  logic             done;
  logic [SW-1:0]    state_o;
  logic [CNT_W-1:0] jmp_cnt;

  modport master (
    output go, jmp, hold, abort,
    input  y1, busy, done, state_o, jmp_cnt
  );

  modport slave (
    input  go, jmp, hold, abort,
    output y1, busy, done, state_o, jmp_cnt
  );
endinterface

// File: rtl/jmp_seq_fsm_sat_counter.sv
// Saturating up-counter used for the jump count; sticks at all-ones until reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jmp_seq_fsm.sv
// Parametrised go/jmp sequencer with hold, abort, done pulse and saturating jump count.
// Define JMP_SEQ_REG_OUT_EN to source y1/busy from flops instead of state decodes.
module jmp_seq_fsm
  import fsm_pkg::*;
#(
  parameter int NSTATES   = NSTATES_DEF,
  parameter int JMP_STATE = JMP_STATE_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SW        = $clog2(NSTATES)
) (
  input logic          clk,
  input logic          rst_n,
  jmp_seq_fsm_if.slave bus
);

  if (!params_ok(NSTATES, JMP_STATE, CNT_W)) begin : g_param_err
    $error("jmp_seq_fsm: illegal NSTATES/JMP_STATE/CNT_W combination");
  end

  localparam logic [SW-1:0] IDLE = SW'(S_IDLE);
  localparam logic [SW-1:0] LAST = SW'(NSTATES - 1);
  localparam logic [SW-1:0] JMP  = SW'(JMP_STATE);
  localparam logic [SW:0]   NST  = (SW + 1)'(NSTATES);

  logic [SW-1:0]    state_q;
  logic [SW-1:0]    state_d;
  logic             done_q;
  logic             done_d;
  logic             jmp_taken;
  logic [CNT_W-1:0] jmp_cnt_w;
  move_e            move;

  // Illegal encodings recover before hold is honoured so a frozen bad state cannot persist.
  always_comb begin
    move      = MV_STAY;
    done_d    = 1'b0;
    jmp_taken = 1'b0;
    state_d   = state_q;
    if (bus.abort) begin
      move = MV_IDLE;
    end else if ({1'b0, state_q} >= NST) begin
      move = MV_IDLE;
    end else if (bus.hold) begin
      done_d = done_q;
    end else if (state_q == IDLE) begin
      if (bus.go) move = bus.jmp ? MV_JUMP : MV_NEXT;
    end else if (bus.jmp) begin
      move = MV_JUMP;
    end else if (state_q == LAST) begin
      move   = MV_IDLE;
      done_d = 1'b1;
    end else begin
      move = MV_NEXT;
    end
    jmp_taken = (move == MV_JUMP) && (state_q != JMP);
    case (move)
      MV_NEXT: state_d = state_q + 1'b1;
      MV_JUMP: state_d = JMP;
      MV_IDLE: state_d = IDLE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_jmp_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (jmp_taken),
    .q    (jmp_cnt_w)
  );

`ifdef JMP_SEQ_REG_OUT_EN
  logic y1_q;
  logic busy_q;

  // Loaded from the next-state decode so they line up with state_q after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      y1_q   <= (state_d == JMP);
      busy_q <= (state_d != IDLE);
    end
  end

  assign bus.y1   = y1_q;
  assign bus.busy = busy_q;
`else
  assign bus.y1   = (state_q == JMP);
  assign bus.busy = (state_q != IDLE);
`endif

  assign bus.done    = done_q;
  assign bus.state_o = state_q;
  assign bus.jmp_cnt = jmp_cnt_w;

endmodule

// File: tb/tb_jmp_seq_fsm.sv
// Bench for jmp_seq_fsm: default instance driven from a vector table through a scoreboard,
// plus a small NSTATES=4/JMP_STATE=3/CNT_W=2 instance for saturation and last-state jumps.
module tb_jmp_seq_fsm;

  typedef struct {
    logic       go;
    logic       jmp;
    logic       hold;
    logic       abort;
    logic [3:0] state;
    logic [7:0] cnt;
    logic       done;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  vec_t tbl[$];
  vec_t exp_q[$];

  jmp_seq_fsm_if #(.SW(4), .CNT_W(8)) bus ();
  jmp_seq_fsm_if #(.SW(2), .CNT_W(2)) bus2 ();

  jmp_seq_fsm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  jmp_seq_fsm #(.NSTATES(4), .JMP_STATE(3), .CNT_W(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] ins, input int st, input int cnt, input logic dn);
    vec_t v;
    v.go    = ins[3];
    v.jmp   = ins[2];
    v.hold  = ins[1];
    v.abort = ins[0];
    v.state = 4'(st);
    v.cnt   = 8'(cnt);
    v.done  = dn;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.go    = v.go;
    bus.jmp   = v.jmp;
    bus.hold  = v.hold;
    bus.abort = v.abort;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    logic ey1;
    logic ebusy;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: got no expected entry, want one queued", tag);
      return;
    end
    e     = exp_q.pop_front();
    ey1   = (e.state == 4'd3);
    ebusy = (e.state != 4'd0);
    if ({bus.state_o, bus.y1, bus.busy, bus.done, bus.jmp_cnt} !==
        {e.state, ey1, ebusy, e.done, e.cnt}) begin
      miscompares++;
      $display("[TB] FAIL %s: got state=%0d y1=%b busy=%b done=%b cnt=%0d, want state=%0d y1=%b busy=%b done=%b cnt=%0d",
               tag, bus.state_o, bus.y1, bus.busy, bus.done, bus.jmp_cnt,
               e.state, ey1, ebusy, e.done, e.cnt);
    end
  endtask

  task automatic step2(input logic g, input logic j);
    bus2.go  = g;
    bus2.jmp = j;
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string tag, input logic [1:0] st, input logic [1:0] cnt, input logic dn);
    logic ey1;
    logic ebusy;
    ey1   = (st == 2'd3);
    ebusy = (st != 2'd0);
    vectors++;
    if ({bus2.state_o, bus2.y1, bus2.busy, bus2.done, bus2.jmp_cnt} !== {st, ey1, ebusy, dn, cnt}) begin
      miscompares++;
      $display("[TB] FAIL %s: got state=%0d y1=%b busy=%b done=%b cnt=%0d, want state=%0d y1=%b busy=%b done=%b cnt=%0d",
               tag, bus2.state_o, bus2.y1, bus2.busy, bus2.done, bus2.jmp_cnt, st, ey1, ebusy, dn, cnt);
    end
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.go      = 1'b0;
    bus.jmp     = 1'b0;
    bus.hold    = 1'b0;
    bus.abort   = 1'b0;
    bus2.go     = 1'b0;
    bus2.jmp    = 1'b0;
    bus2.hold   = 1'b0;
    bus2.abort  = 1'b0;
    sat_exp     = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Full pass without jmp, then wrap with a single done pulse.
    tbl.push_back(mk(4'b1000, 1, 0, 1'b0));
    for (int s = 2; s <= 9; s++) tbl.push_back(mk(4'b0000, s, 0, 1'b0));
    tbl.push_back(mk(4'b0000, 0, 0, 1'b1));
    tbl.push_back(mk(4'b0000, 0, 0, 1'b0));
    // go+jmp from idle, self-loop does not count, jump back from S7.
    tbl.push_back(mk(4'b1100, 3, 1, 1'b0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b0100, 3, 1, 1'b0));
    for (int s = 4; s <= 7; s++) tbl.push_back(mk(4'b0000, s, 1, 1'b0));
    tbl.push_back(mk(4'b0100, 3, 2, 1'b0));
    for (int s = 4; s <= 9; s++) tbl.push_back(mk(4'b0000, s, 2, 1'b0));
    tbl.push_back(mk(4'b0000, 0, 2, 1'b1));
    // Hold with jmp at S5, then abort beats hold.
    tbl.push_back(mk(4'b1000, 1, 2, 1'b0));
    for (int s = 2; s <= 5; s++) tbl.push_back(mk(4'b0000, s, 2, 1'b0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b0110, 5, 2, 1'b0));
    tbl.push_back(mk(4'b0111, 0, 2, 1'b0));
    tbl.push_back(mk(4'b0000, 0, 2, 1'b0));
    // Idle ignores jmp alone and go under hold; abort from the last state gives no done.
    tbl.push_back(mk(4'b0100, 0, 2, 1'b0));
    tbl.push_back(mk(4'b1010, 0, 2, 1'b0));
    tbl.push_back(mk(4'b1000, 1, 2, 1'b0));
    tbl.push_back(mk(4'b0001, 0, 2, 1'b0));
    tbl.push_back(mk(4'b1000, 1, 2, 1'b0));
    for (int s = 2; s <= 9; s++) tbl.push_back(mk(4'b0000, s, 2, 1'b0));
    tbl.push_back(mk(4'b0001, 0, 2, 1'b0));
    tbl.push_back(mk(4'b0000, 0, 2, 1'b0));

    #3;
    exp_q.push_back(mk(4'b0000, 0, 0, 1'b0));
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Asynchronous reset in mid-cycle at S6.
    applyStimulus(mk(4'b1000, 1, 2, 1'b0));
    checkOutput("rst_run1");
    for (int s = 2; s <= 6; s++) begin
      applyStimulus(mk(4'b0000, s, 2, 1'b0));
      checkOutput($sformatf("rst_run%0d", s));
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(4'b0000, 0, 0, 1'b0));
    checkOutput("async_reset");
    check2("async_reset2", 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(4'b0000, 0, 0, 1'b0));
    checkOutput("post_rst_idle");
    applyStimulus(mk(4'b1000, 1, 0, 1'b0));
    checkOutput("post_rst_go");
    applyStimulus(mk(4'b0001, 0, 0, 1'b0));
    checkOutput("post_rst_abort");

    // Small instance: jump target is the last state, counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      step2(1'b1, 1'b1);
      check2($sformatf("sat_jump%0d", i), 2'd3, sat_exp[i], 1'b0);
      step2(1'b0, 1'b1);
      check2($sformatf("sat_loop%0d", i), 2'd3, sat_exp[i], 1'b0);
      step2(1'b0, 1'b0);
      check2($sformatf("sat_wrap%0d", i), 2'd0, sat_exp[i], 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jmp_seq_fsm.md
# jmp_seq_fsm

Parametrised jump-sequencer FSM, the next generation of the fixed ten-state go/jmp controller. The sequence length, jump-target state and counter widths are parameters. It adds hold, abort, busy/done status, a visible state index and a saturating jump counter. It sits in the FMS_Ex design set as a reusable control sequencer driven by external `go`/`jmp` strobes.

## Interface
- `NSTATES`, default 10: number of states S0..S(NSTATES-1); legal range ≥ 3.
- `JMP_STATE`, default 3: jump-target state index; legal range 1..NSTATES-1.
- `CNT_W`, default 8: width of `jmp_cnt`.
- `SW`, default `$clog2(NSTATES)`: state index width (derived; not overridden).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `go`  in  1  start request, sampled only in S0.
- `jmp`  in  1  jump request.
- `hold`  in  1  freeze state and counters.
- `abort`  in  1  synchronous return to S0.
- `y1`  out  1  high while state == JMP_STATE.
- `busy`  out  1  high while state != S0.
- `done`  out  1  one-cycle pulse after wrap from the last state to S0.
- `state_o`  out  SW  current state index.
- `jmp_cnt`  out  CNT_W  count of jumps taken, saturating.

## Operation
- Next-state priority: abort > hold > sequence rules.
- abort: next = S0 from any state. `jmp_cnt` holds its value. No `done` pulse.
- hold (abort low): state, `jmp_cnt` and `done` generation are frozen. Inputs `go`/`jmp` are ignored that cycle.
- Sequence rules:
  - S0: go=0 → S0; go=1 with jmp=1 → JMP_STATE; go=1 with jmp=0 → S1.
  - Si, 1 ≤ i < NSTATES-1: jmp=1 → JMP_STATE, else S(i+1).
  - S(NSTATES-1): jmp=1 → JMP_STATE, else S0 (wrap).
  - JMP_STATE with jmp=1 → JMP_STATE (self-loop).
- Illegal encodings (index ≥ NSTATES) → S0 next cycle. No output other than `busy`/`state_o` reflects them.
- `jmp_cnt` increments on every transition into JMP_STATE caused by jmp from a state other than JMP_STATE, including S0 with go&jmp.
  - The JMP_STATE self-loop does not count.
  - Natural entry into JMP_STATE without jmp does not count.
  - Saturates at 2^CNT_W-1 and never wraps. Cleared only by reset.
- `done` is registered: high for exactly the cycle in which state == S0 after a non-jump, non-abort exit from S(NSTATES-1).
- `y1` and `busy` are pure decodes of the current state. `state_o` equals the state register.

## Timing
- Reset values: state S0; `y1`=0, `busy`=0, `done`=0, `state_o`=0, `jmp_cnt`=0.
- `go` sampled in S0 at edge k gives state S1 (or JMP_STATE) in cycle k+1.
- Full pass with no jmp: go at edge k, then S(NSTATES-1) at k+NSTATES-1, then S0 with `done`=1 at k+NSTATES.
- Asserting `rst_n` mid-sequence forces all reset values immediately. Sequencing resumes on the first edge after deassertion.
- abort and hold in the same cycle: abort wins.
- With JMP_STATE = NSTATES-1: jmp in the last state self-loops. A wrap still requires jmp=0.

## Configuration
- `JMP_SEQ_REG_OUT_EN` defined:
  - `y1` and `busy` come from flops loaded with the decode of the next state.
  - They stay cycle-aligned with the state register and are glitch-free.
  - Reset value is 0.
- Not defined: `y1` and `busy` are combinational decodes of the state register.
- Cycle-level behaviour is identical either way. Only glitch freedom and output timing paths differ.

## Structure
- Package `fsm_pkg` holds:
  - the default `NSTATES`, `JMP_STATE` and `CNT_W` values;
  - the `S_IDLE`=0 constant;
  - elaboration checks for the legal parameter ranges.
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst_n`, `inc`, `q`) implements `jmp_cnt`. Its `inc` is qualified by hold/abort in the parent.

## Test plan
- Defaults, one-cycle go pulse, jmp=0:
  - `state_o` runs 1..9 then 0.
  - `y1`=1 only in the `state_o`=3 cycle.
  - `done`=1 exactly 10 cycles after go, `busy` low again.
- go=1 with jmp=1 in S0:
  - next `state_o`=3, `y1`=1, `jmp_cnt`=1.
  - Holding jmp for 4 more cycles keeps state 3 and `jmp_cnt` stays 1.
- Run to S7, then jmp for 1 cycle:
  - state returns to 3 and `jmp_cnt` increments.
  - Release jmp: states 4..9 then 0 with `done` pulse.
- hold=1 for 5 cycles at S5 with jmp=1: `state_o` stays 5 and `jmp_cnt` is unchanged. abort=1 with hold=1 at S5 gives S0 next cycle, no `done`.
- CNT_W=2: force 5 jumps → `jmp_cnt` reads 1, 2, 3, 3, 3.
- Assert `rst_n`=0 asynchronously mid-cycle at S6: all outputs zero before the next edge. Repeat the run with `JMP_SEQ_REG_OUT_EN` defined and check identical cycle traces.
